// File: rtl/akuma_anim_seq.sv
// Player-2 animation sequencer: per-frame state, sprite frame index, attack strobe and busy lock.
// Optional feature: define AKUMA_ANIM_AIR_ATTACK_EN to allow attacks launched from JUMP.
module akuma_anim_seq #(
    parameter int unsigned HOLD         = 4,
    parameter int unsigned IDLE_FRAMES  = 4,
    parameter int unsigned WALK_FRAMES  = 5,
    parameter int unsigned PUNCH_FRAMES = 3,
    parameter int unsigned KICK_FRAMES  = 4,
    parameter int unsigned PUNCH_ACTIVE = 1,
    parameter int unsigned KICK_ACTIVE  = 2
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       GamePlaying,
    input  logic       AkumaJump,
    input  logic       AkumaCrouch,
    input  logic       AkumaLeft,
    input  logic       AkumaRight,
    input  logic       Punch,
    input  logic       Kick,
    output logic [2:0] AnimState,
    output logic [2:0] FrameIdx,
    output logic       AttackActive,
    output logic       Busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WALK_FWD  = 3'd1,
        S_WALK_BACK = 3'd2,
        S_CROUCH    = 3'd3,
        S_JUMP      = 3'd4,
        S_PUNCH     = 3'd5,
        S_KICK      = 3'd6
    } state_t;

    state_t     r_state;
    logic [2:0] r_frame;
    logic [3:0] r_hold;
    logic       r_punch_prev;
    logic       r_kick_prev;

    state_t     w_sel;
    state_t     w_attack_exit;
    state_t     w_state_nxt;
    logic [2:0] w_frame_nxt;
    logic [3:0] w_hold_nxt;
    logic       w_punch_edge;
    logic       w_kick_edge;
    logic       w_hold_done;
    logic       w_last_frame;
    logic       w_attack_nxt;

    assign w_punch_edge = Punch & ~r_punch_prev;
    assign w_kick_edge  = Kick & ~r_kick_prev;
    assign w_hold_done  = (r_hold == 4'(HOLD - 1));

    // Candidate state when not locked in an attack.
    always_comb begin
        w_sel = S_IDLE;
`ifdef AKUMA_ANIM_AIR_ATTACK_EN
        if (AkumaJump && !(r_state == S_JUMP && (w_punch_edge || w_kick_edge)))
            w_sel = S_JUMP;
`else
        if (AkumaJump)
            w_sel = S_JUMP;
`endif
        else if (w_punch_edge)
            w_sel = S_PUNCH;
        else if (w_kick_edge)
            w_sel = S_KICK;
        else if (AkumaCrouch)
            w_sel = S_CROUCH;
        else if (AkumaLeft)
            w_sel = S_WALK_FWD;
        else if (AkumaRight)
            w_sel = S_WALK_BACK;
    end

`ifdef AKUMA_ANIM_AIR_ATTACK_EN
    assign w_attack_exit = AkumaJump ? S_JUMP : S_IDLE;
`else
    assign w_attack_exit = S_IDLE;
`endif

    always_comb begin
        w_last_frame = 1'b1;
        case (r_state)
            S_IDLE:                  w_last_frame = (r_frame == 3'(IDLE_FRAMES - 1));
            S_WALK_FWD, S_WALK_BACK: w_last_frame = (r_frame == 3'(WALK_FRAMES - 1));
            S_PUNCH:                 w_last_frame = (r_frame == 3'(PUNCH_FRAMES - 1));
            S_KICK:                  w_last_frame = (r_frame == 3'(KICK_FRAMES - 1));
            default:                 w_last_frame = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_hold_nxt  = r_hold;
        if (GamePlaying) begin
            if (r_state == S_PUNCH || r_state == S_KICK) begin
                if (w_hold_done) begin
                    w_hold_nxt = '0;
                    if (w_last_frame) begin
                        w_state_nxt = w_attack_exit;
                        w_frame_nxt = '0;
                    end else begin
                        w_frame_nxt = r_frame + 3'd1;
                    end
                end else begin
                    w_hold_nxt = r_hold + 4'd1;
                end
            end else if (w_sel != r_state) begin
                w_state_nxt = w_sel;
                w_frame_nxt = '0;
                w_hold_nxt  = '0;
            end else if (w_hold_done) begin
                w_hold_nxt = '0;
                if (r_state == S_JUMP || r_state == S_CROUCH || w_last_frame)
                    w_frame_nxt = '0;
                else
                    w_frame_nxt = r_frame + 3'd1;
            end else begin
                w_hold_nxt = r_hold + 4'd1;
            end
        end
    end

    assign w_attack_nxt = (w_state_nxt == S_PUNCH && w_frame_nxt == 3'(PUNCH_ACTIVE)) ||
                          (w_state_nxt == S_KICK  && w_frame_nxt == 3'(KICK_ACTIVE));

    // Edge-detect history updates even while frozen, so held buttons never fire on resume.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_frame      <= '0;
            r_hold       <= '0;
            r_punch_prev <= 1'b0;
            r_kick_prev  <= 1'b0;
            AttackActive <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame      <= w_frame_nxt;
            r_hold       <= w_hold_nxt;
            r_punch_prev <= Punch;
            r_kick_prev  <= Kick;
            AttackActive <= w_attack_nxt;
            Busy         <= (w_state_nxt == S_PUNCH) || (w_state_nxt == S_KICK);
        end
    end

    assign AnimState = r_state;
    assign FrameIdx  = r_frame;

endmodule

// File: tb/tb_akuma_anim_seq.sv
// Scoreboard bench for akuma_anim_seq: driver queues expected outputs per frame, monitor compares.
module tb_akuma_anim_seq;

    logic       frame_clk = 1'b0;
    logic       Reset, GamePlaying;
    logic       AkumaJump, AkumaCrouch, AkumaLeft, AkumaRight, Punch, Kick;
    logic [2:0] AnimState, FrameIdx;
    logic       AttackActive, Busy;

    typedef struct packed {
        logic [7:0] tag;
        logic [2:0] st;
        logic [2:0] fi;
        logic       aa;
        logic       bz;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    akuma_anim_seq #(
        .HOLD(4), .IDLE_FRAMES(4), .WALK_FRAMES(5), .PUNCH_FRAMES(3),
        .KICK_FRAMES(4), .PUNCH_ACTIVE(1), .KICK_ACTIVE(2)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .GamePlaying(GamePlaying),
        .AkumaJump(AkumaJump), .AkumaCrouch(AkumaCrouch),
        .AkumaLeft(AkumaLeft), .AkumaRight(AkumaRight),
        .Punch(Punch), .Kick(Kick),
        .AnimState(AnimState), .FrameIdx(FrameIdx),
        .AttackActive(AttackActive), .Busy(Busy)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic cyc(input int tag, input int st, input int fi, input bit aa, input bit bz);
        exp_t e;
        @(posedge frame_clk);
        #1;
        e.tag = 8'(tag);
        e.st  = 3'(st);
        e.fi  = 3'(fi);
        e.aa  = aa;
        e.bz  = bz;
        q.push_back(e);
    endtask

    // Frames 1..11 of a punch after the entry frame.
    task automatic punch_body(input int tag);
        for (int i = 1; i < 12; i++) cyc(tag, 5, i / 4, (i / 4) == 1, 1'b1);
    endtask

    initial begin
        Reset = 1'b1; GamePlaying = 1'b0;
        AkumaJump = 1'b0; AkumaCrouch = 1'b0; AkumaLeft = 1'b0; AkumaRight = 1'b0;
        Punch = 1'b0; Kick = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        Reset = 1'b0; GamePlaying = 1'b1;

        for (int n = 1; n <= 20; n++) cyc(1, 0, (n / 4) % 4, 0, 0);

        AkumaLeft = 1'b1;
        for (int m = 1; m <= 25; m++) cyc(2, 1, ((m - 1) / 4) % 5, 0, 0);

        AkumaLeft = 1'b0; AkumaRight = 1'b1;
        cyc(3, 2, 0, 0, 0);
        Punch = 1'b1;
        cyc(3, 5, 0, 0, 1);
        Punch = 1'b0;
        punch_body(3);
        cyc(3, 0, 0, 0, 0);
        cyc(3, 2, 0, 0, 0);
        AkumaRight = 1'b0;
        cyc(4, 0, 0, 0, 0);

        Punch = 1'b1;
        cyc(4, 5, 0, 0, 1);
        punch_body(4);
        cyc(4, 0, 0, 0, 0);
        for (int s = 13; s < 40; s++) cyc(4, 0, ((s - 12) / 4) % 4, 0, 0);
        Punch = 1'b0;

        Kick = 1'b1;
        cyc(5, 6, 0, 0, 1);
        for (int i = 1; i < 6; i++) cyc(5, 6, i / 4, (i / 4) == 2, 1'b1);
        GamePlaying = 1'b0;
        for (int f = 0; f < 10; f++) cyc(5, 6, 1, 0, 1);
        Kick = 1'b0; GamePlaying = 1'b1;
        for (int i = 6; i < 16; i++) cyc(5, 6, i / 4, (i / 4) == 2, 1'b1);
        cyc(5, 0, 0, 0, 0);

        Punch = 1'b1; Kick = 1'b1;
        cyc(6, 5, 0, 0, 1);
        Punch = 1'b0; Kick = 1'b0;
        punch_body(6);
        cyc(6, 0, 0, 0, 0);

        Kick = 1'b1;
        cyc(7, 6, 0, 0, 1);
        Kick = 1'b0;
        for (int i = 1; i < 5; i++) cyc(7, 6, i / 4, (i / 4) == 2, 1'b1);
        Reset = 1'b1;
        cyc(7, 0, 0, 0, 0);
        Reset = 1'b0;
        cyc(7, 0, 0, 0, 0);

        AkumaJump = 1'b1;
        for (int i = 0; i < 4; i++) cyc(8, 4, 0, 0, 0);
        Kick = 1'b1;
`ifdef AKUMA_ANIM_AIR_ATTACK_EN
        cyc(8, 6, 0, 0, 1);
        Kick = 1'b0;
        for (int i = 1; i < 16; i++) cyc(8, 6, i / 4, (i / 4) == 2, 1'b1);
        cyc(8, 4, 0, 0, 0);
`else
        for (int i = 0; i < 6; i++) cyc(8, 4, 0, 0, 0);
        Kick = 1'b0;
        cyc(8, 4, 0, 0, 0);
`endif
        AkumaJump = 1'b0;
        cyc(9, 0, 0, 0, 0);
        AkumaCrouch = 1'b1;
        for (int i = 0; i < 6; i++) cyc(9, 3, 0, 0, 0);
        AkumaCrouch = 1'b0; AkumaLeft = 1'b1; AkumaRight = 1'b1;
        cyc(9, 1, 0, 0, 0);
        cyc(9, 1, 0, 0, 0);
        AkumaJump = 1'b1; Punch = 1'b1;
        cyc(10, 4, 0, 0, 0);
        AkumaJump = 1'b0; Punch = 1'b0; AkumaLeft = 1'b0; AkumaRight = 1'b0;
        cyc(10, 0, 0, 0, 0);
        stim_done = 1'b1;
    end

    initial begin
        exp_t e;
        int   cycles;
        cycles = 0;
        while (1) begin
            @(negedge frame_clk);
            cycles++;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if ({AnimState, FrameIdx, AttackActive, Busy} !== {e.st, e.fi, e.aa, e.bz}) begin
                    bad++;
                    $display("FAIL phase%0d t=%0t got st=%0d fi=%0d aa=%0b bz=%0b exp st=%0d fi=%0d aa=%0b bz=%0b",
                             e.tag, $time, AnimState, FrameIdx, AttackActive, Busy,
                             e.st, e.fi, e.aa, e.bz);
                end
            end else if (stim_done) begin
                break;
            end
            if (cycles > 5000) begin
                bad++;
                $display("FAIL timeout cycles=%0d pending=%0d", cycles, q.size());
                break;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
